// File: rtl/vga_step_ctrl_if.sv
// rtl/vga_step_ctrl_if.sv - Gain-write, home, readback and step-pulse bundle for vga_step_ctrl
interface vga_step_ctrl_if #(
    parameter int NCH = 8,
    parameter int GW  = 6
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [GW-1:0]  cfg_gain;
    logic           home_req;
    logic [2:0]     rd_ch;
    logic [GW-1:0]  rd_gain;
    logic [NCH-1:0] up;
    logic [NCH-1:0] down;
    logic           busy;

    modport master (output cfg_valid, cfg_ch, cfg_gain, home_req, rd_ch,
                    input  cfg_ready, rd_gain, up, down, busy);
    modport slave  (input  cfg_valid, cfg_ch, cfg_gain, home_req, rd_ch,
                    output cfg_ready, rd_gain, up, down, busy);
endinterface

// File: rtl/vga_step_ctrl.sv
// rtl/vga_step_ctrl.sv - Steps per-channel VGA gain codes toward targets with up/down pulses
module vga_step_ctrl #(
    parameter int NCH     = 8,
    parameter int GW      = 6,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic           clk_1M,
    input  logic           rst,
    vga_step_ctrl_if.slave bus
);
    localparam logic [GW-1:0] MAX_GAIN = '1;
    localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_W - 1);

    typedef enum logic [2:0] {IDLE, ASSERT, GAP, HOME_ASSERT, HOME_GAP} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [GW-1:0]  home_cnt, home_cnt_nxt;
    logic [NCH-1:0] up_r, down_r, up_nxt, down_nxt;
    logic [NCH-1:0] dir_up, dir_dn, cmp_up, cmp_dn;
    logic [GW-1:0]  cur [NCH];
    logic [GW-1:0]  tgt [NCH];
    logic [GW-1:0]  rd_gain;
    logic           latch_dir, step_cur, clear_all, wr_en;

    assign bus.cfg_ready = (state == IDLE) || (state == GAP);
    assign bus.busy      = (state != IDLE);
    assign bus.up        = up_r;
    assign bus.down      = down_r;
    assign bus.rd_gain   = rd_gain;
    assign wr_en         = bus.cfg_valid && bus.cfg_ready;

    // Compare uses registered tgt, so a write this cycle only shows up next compare
    always_comb begin
        cmp_up = '0;
        cmp_dn = '0;
        for (int i = 0; i < NCH; i++) begin
            cmp_up[i] = cur[i] < tgt[i];
            cmp_dn[i] = cur[i] > tgt[i];
        end
    end

    always_comb begin
        rd_gain = '0;
        for (int i = 0; i < NCH; i++)
            if (int'(bus.rd_ch) == i) rd_gain = cur[i];
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        home_cnt_nxt = home_cnt;
        up_nxt       = '0;
        down_nxt     = '0;
        latch_dir    = 1'b0;
        step_cur     = 1'b0;
        clear_all    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.home_req) begin
                    state_nxt    = HOME_ASSERT;
                    home_cnt_nxt = '0;
                    down_nxt     = '1;
                end else begin
                    latch_dir = 1'b1;
                    if (|(cmp_up | cmp_dn)) begin
                        state_nxt = ASSERT;
                        up_nxt    = cmp_up;
                        down_nxt  = cmp_dn;
                    end
                end
            end
            ASSERT: begin
                if (cnt == P_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    step_cur  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    up_nxt   = dir_up;
                    down_nxt = dir_dn;
                end
            end
            GAP: begin
                if (cnt == G_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOME_ASSERT: begin
                if (cnt == P_LAST) begin
                    state_nxt = HOME_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    down_nxt = '1;
                end
            end
            HOME_GAP: begin
                if (cnt == G_LAST) begin
                    cnt_nxt = '0;
                    if (home_cnt == MAX_GAIN) begin
                        state_nxt = IDLE;
                        clear_all = 1'b1;
                    end else begin
                        state_nxt    = HOME_ASSERT;
                        home_cnt_nxt = home_cnt + 1'b1;
                        down_nxt     = '1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            home_cnt <= '0;
            up_r     <= '0;
            down_r   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            home_cnt <= home_cnt_nxt;
            up_r     <= up_nxt;
            down_r   <= down_nxt;
        end
    end

    // cur moves only on the ASSERT->GAP edge, so a reset mid-pulse leaves no partial step
    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            dir_up <= '0;
            dir_dn <= '0;
            for (int i = 0; i < NCH; i++) begin
                cur[i] <= '0;
                tgt[i] <= '0;
            end
        end else begin
            if (latch_dir) begin
                dir_up <= cmp_up;
                dir_dn <= cmp_dn;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clear_all) begin
                    cur[i] <= '0;
                    tgt[i] <= '0;
                end else begin
                    if (wr_en && int'(bus.cfg_ch) == i) tgt[i] <= bus.cfg_gain;
                    if (step_cur && dir_up[i])      cur[i] <= cur[i] + 1'b1;
                    else if (step_cur && dir_dn[i]) cur[i] <= cur[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_step_ctrl.sv
// tb/tb_vga_step_ctrl.sv - Randomized step-level model bench for vga_step_ctrl
module tb_vga_step_ctrl;
    localparam int NCH     = 8;
    localparam int GW      = 6;
    localparam int PULSE_W = 2;
    localparam int GAP_W   = 2;
    localparam int MAXG    = (1 << GW) - 1;

    logic clk_1M = 1'b0;
    logic rst    = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   m_cur [NCH];
    int   m_tgt [NCH];

    vga_step_ctrl_if #(.NCH(NCH), .GW(GW)) bus ();

    vga_step_ctrl #(.NCH(NCH), .GW(GW), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
        .clk_1M (clk_1M),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 clk_1M = ~clk_1M;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_done();
        for (int i = 0; i < NCH; i++)
            if (m_cur[i] != m_tgt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_cur[i] = 0;
            m_tgt[i] = 0;
        end
    endtask

    task automatic write_cfg(input int ch, input int gain, input bit upd);
        int n = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 3'(ch);
        bus.cfg_gain  = GW'(gain);
        while (!bus.cfg_ready && n < 20) begin
            @(negedge clk_1M);
            n++;
        end
        check_eq("wr_ready", 64'(bus.cfg_ready), 64'd1);
        @(posedge clk_1M);
        @(negedge clk_1M);
        bus.cfg_valid = 1'b0;
        if (upd && ch < NCH) m_tgt[ch] = gain;
    endtask

    task automatic check_rd();
        for (int i = 0; i < NCH; i++) begin
            bus.rd_ch = 3'(i);
            #1;
            check_eq("rd_gain", 64'(bus.rd_gain), 64'(m_cur[i]));
        end
        @(negedge clk_1M);
    endtask

    // One step: each channel moves one code toward its target, all in parallel
    task automatic step_check(input int lat);
        logic [NCH-1:0] eu, ed;
        int n = 0;
        eu = '0;
        ed = '0;
        for (int i = 0; i < NCH; i++) begin
            eu[i] = m_cur[i] < m_tgt[i];
            ed[i] = m_cur[i] > m_tgt[i];
        end
        while ((bus.up | bus.down) == '0 && n < 10) begin
            @(negedge clk_1M);
            n++;
        end
        check_eq("step_lat", 64'(n), 64'(lat));
        for (int p = 0; p < PULSE_W; p++) begin
            check_eq("pulse", 64'({bus.up, bus.down}), 64'({eu, ed}));
            check_eq("pulse_ready", 64'(bus.cfg_ready), 64'd0);
            @(negedge clk_1M);
        end
        for (int g = 0; g < GAP_W; g++) begin
            check_eq("gap", 64'({bus.up, bus.down}), 64'd0);
            check_eq("gap_busy", 64'(bus.busy), 64'd1);
            @(negedge clk_1M);
        end
        for (int i = 0; i < NCH; i++)
            m_cur[i] += eu[i] ? 1 : (ed[i] ? -1 : 0);
    endtask

    task automatic settle();
        int steps = 0;
        while (!model_done() && steps < MAXG + 5) begin
            step_check(1);
            steps++;
        end
        check_eq("settled", 64'(model_done()), 64'd1);
        repeat (3) begin
            check_eq("idle_out", 64'({bus.up, bus.down, bus.busy}), 64'd0);
            @(negedge clk_1M);
        end
        check_rd();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_gain  = '0;
        bus.home_req  = 1'b0;
        bus.rd_ch     = '0;
        model_clear();

        repeat (3) @(negedge clk_1M);
        check_eq("rst_updown", 64'({bus.up, bus.down}), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_ready", 64'(bus.cfg_ready), 64'd1);
        check_rd();
        rst = 1'b0;

        write_cfg(2, 3, 1'b1);
        settle();

        write_cfg(0, 5, 1'b1);
        settle();
        write_cfg(0, 2, 1'b1);
        settle();

        write_cfg(7, MAXG, 1'b1);
        settle();
        write_cfg(7, 0, 1'b1);
        settle();

        for (int r = 0; r < 10; r++) begin
            write_cfg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, MAXG)), 1'b1);
            settle();
        end

        write_cfg(3, 10, 1'b1);
        settle();
        bus.home_req = 1'b1;
        @(negedge clk_1M);
        bus.home_req = 1'b0;
        for (int k = 0; k <= MAXG; k++) begin
            for (int p = 0; p < PULSE_W; p++) begin
                check_eq("home_pulse", 64'({bus.up, bus.down}), 64'({{NCH{1'b0}}, {NCH{1'b1}}}));
                @(negedge clk_1M);
            end
            for (int g = 0; g < GAP_W; g++) begin
                check_eq("home_gap", 64'({bus.up, bus.down}), 64'd0);
                @(negedge clk_1M);
            end
        end
        model_clear();
        settle();

        // Write and home request while a pulse is in flight
        write_cfg(4, 2, 1'b1);
        @(negedge clk_1M);
        check_eq("wa_ready_a1", 64'(bus.cfg_ready), 64'd0);
        check_eq("wa_up_a1", 64'(bus.up), 64'h10);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 3'd4;
        bus.cfg_gain  = '0;
        bus.home_req  = 1'b1;
        @(negedge clk_1M);
        bus.home_req = 1'b0;
        check_eq("wa_ready_a2", 64'(bus.cfg_ready), 64'd0);
        check_eq("wa_up_a2", 64'(bus.up), 64'h10);
        @(negedge clk_1M);
        check_eq("wa_ready_g1", 64'(bus.cfg_ready), 64'd1);
        check_eq("wa_gap1", 64'({bus.up, bus.down}), 64'd0);
        @(posedge clk_1M);
        @(negedge clk_1M);
        bus.cfg_valid = 1'b0;
        check_eq("wa_gap2", 64'({bus.up, bus.down}), 64'd0);
        @(negedge clk_1M);
        check_eq("wa_idle", 64'({bus.up, bus.down, bus.busy}), 64'd0);
        m_cur[4] = 1;
        m_tgt[4] = 0;
        settle();

        // Second write lands as the first step starts, so it joins from step two
        write_cfg(1, 4, 1'b1);
        write_cfg(5, 2, 1'b0);
        step_check(0);
        m_tgt[5] = 2;
        settle();

        write_cfg(2, 3, 1'b1);
        @(negedge clk_1M);
        @(negedge clk_1M);
        check_eq("rst_mid_up", 64'(bus.up), 64'h04);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_updown", 64'({bus.up, bus.down}), 64'd0);
        check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_mid_ready", 64'(bus.cfg_ready), 64'd1);
        bus.rd_ch = 3'd2;
        #1;
        check_eq("rst_mid_rd2", 64'(bus.rd_gain), 64'd0);
        model_clear();
        @(negedge clk_1M);
        @(negedge clk_1M);
        rst = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
